// File: rtl/icu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icu_pkg
//  Description : Opcode constants and sequencer state encoding shared by the
//                ICU sequencer and the ICU control decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package icu_pkg;

    localparam logic [3:0] OP_NOP0 = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } seq_state_e;

    // Opcodes consumed by the sequencer and never issued to the ICU.
    // NOP0 is deliberately absent: it raises flag0 and also reaches the ICU.
    function automatic logic is_local_op(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_RTN) || (op == OP_SKZ) || (op == OP_NOPF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/icu_ret_stack.sv
`default_nettype none
// ============================================================================
//  Module      : icu_ret_stack
//  Description : RET_DEPTH x ADDR_W LIFO of return addresses. A push while
//                full or a pop while empty leaves the contents untouched; the
//                caller decides how to report it.
//  Revision    : 1.0 - initial release
// ============================================================================
module icu_ret_stack #(
    parameter int ADDR_W    = 8,
    parameter int RET_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int CNT_W = $clog2(RET_DEPTH + 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ent_q [RET_DEPTH];
    logic [ADDR_W-1:0] ent_d [RET_DEPTH];

    assign full  = (cnt_q == CNT_W'(RET_DEPTH));
    assign empty = (cnt_q == '0);

    // Top-of-stack read and push/pop bookkeeping.
    always_comb begin
        cnt_d = cnt_q;
        ent_d = ent_q;
        top   = '0;
        for (int i = 0; i < RET_DEPTH; i++) begin
            if (cnt_q == CNT_W'(i + 1)) begin
                top = ent_q[i];
            end
        end
        if (push && !full) begin
            for (int i = 0; i < RET_DEPTH; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    ent_d[i] = push_data;
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !empty) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Stack storage and depth counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            for (int i = 0; i < RET_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            ent_q <= ent_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/icu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : icu_sequencer
//  Description : Program sequencer for the 1-bit ICU. Fetches opcode/operand
//                pairs over a req/ack handshake, executes JMP/RTN/SKZ/NOPx
//                locally and issues the remaining opcodes to the ICU.
//  Revision    : 1.0 - initial release
// ============================================================================
module icu_sequencer
    import icu_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int RET_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [3:0]        mem_inst,
    input  logic [ADDR_W-1:0] mem_opnd,
    output logic [3:0]        icu_inst,
    output logic              icu_valid,
    input  logic              rr,
    output logic              flag0,
    output logic              flagf,
    output logic [ADDR_W-1:0] pc,
    output logic              stack_err
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] opnd_q, opnd_d;
    logic [3:0]        op_q, op_d;
    logic              skip_q, skip_d;
    logic              mem_req_q, mem_req_d;
    logic [3:0]        icu_inst_q, icu_inst_d;
    logic              icu_valid_q, icu_valid_d;
    logic              flag0_q, flag0_d;
    logic              flagf_q, flagf_d;
    logic              stack_err_q, stack_err_d;

    logic              stk_push;
    logic              stk_pop;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;
    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc = pc_q + ADDR_W'(1);

    icu_ret_stack #(
        .ADDR_W    (ADDR_W),
        .RET_DEPTH (RET_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Next state, PC update and registered ICU outputs. The ICU outputs are
    // computed at the fetch-ack edge so they are live for exactly the EXEC cycle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        opnd_d      = opnd_q;
        op_d        = op_q;
        skip_d      = skip_q;
        mem_req_d   = mem_req_q;
        stack_err_d = stack_err_q;
        icu_inst_d  = 4'h0;
        icu_valid_d = 1'b0;
        flag0_d     = 1'b0;
        flagf_d     = 1'b0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // After reset mem_req is low; it rises on the first edge here.
                if (mem_req_q && mem_ack) begin
                    op_d      = mem_inst;
                    opnd_d    = mem_opnd;
                    mem_req_d = 1'b0;
                    state_d   = ST_EXEC;
                    if (!skip_q) begin
                        if (!is_local_op(mem_inst)) begin
                            icu_inst_d  = mem_inst;
                            icu_valid_d = 1'b1;
                        end
                        flag0_d = (mem_inst == OP_NOP0);
                        flagf_d = (mem_inst == OP_NOPF);
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end

            ST_EXEC: begin
                pc_d      = pc_inc;
                state_d   = halt ? ST_HALT : ST_FETCH;
                mem_req_d = !halt;
                if (skip_q) begin
                    // Skipped slot: consumed with no side effect at all.
                    skip_d = 1'b0;
                end else begin
                    case (op_q)
                        OP_JMP: begin
                            pc_d = opnd_q;
                            if (stk_full) begin
                                stack_err_d = 1'b1;
                            end else begin
                                stk_push = 1'b1;
                            end
                        end
                        OP_RTN: begin
                            if (stk_empty) begin
                                stack_err_d = 1'b1;
                            end else begin
                                stk_pop = 1'b1;
                                pc_d    = stk_top;
                            end
                        end
                        OP_SKZ: begin
                            skip_d = !rr;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            ST_HALT: begin
                if (!halt) begin
                    state_d   = ST_FETCH;
                    mem_req_d = 1'b1;
                end
            end

            default: begin
                state_d   = ST_FETCH;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State, PC and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= '0;
            opnd_q      <= '0;
            op_q        <= 4'h0;
            skip_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            icu_inst_q  <= 4'h0;
            icu_valid_q <= 1'b0;
            flag0_q     <= 1'b0;
            flagf_q     <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            opnd_q      <= opnd_d;
            op_q        <= op_d;
            skip_q      <= skip_d;
            mem_req_q   <= mem_req_d;
            icu_inst_q  <= icu_inst_d;
            icu_valid_q <= icu_valid_d;
            flag0_q     <= flag0_d;
            flagf_q     <= flagf_d;
            stack_err_q <= stack_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = pc_q;
    assign icu_inst  = icu_inst_q;
    assign icu_valid = icu_valid_q;
    assign flag0     = flag0_q;
    assign flagf     = flagf_q;
    assign pc        = pc_q;
    assign stack_err = stack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_icu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icu_sequencer
//  Description : Directed self-checking bench for icu_sequencer with a ROM
//                responder and an issued-instruction scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icu_sequencer;

    localparam int ADDR_W    = 8;
    localparam int RET_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              halt = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [3:0]        mem_inst = 4'h0;
    logic [ADDR_W-1:0] mem_opnd = '0;
    logic [3:0]        icu_inst;
    logic              icu_valid;
    logic              rr = 1'b0;
    logic              flag0;
    logic              flagf;
    logic [ADDR_W-1:0] pc;
    logic              stack_err;

    always #5 clk = ~clk;

    icu_sequencer #(
        .ADDR_W    (ADDR_W),
        .RET_DEPTH (RET_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_inst  (mem_inst),
        .mem_opnd  (mem_opnd),
        .icu_inst  (icu_inst),
        .icu_valid (icu_valid),
        .rr        (rr),
        .flag0     (flag0),
        .flagf     (flagf),
        .pc        (pc),
        .stack_err (stack_err)
    );

    logic [3:0]        rom_i [256];
    logic [ADDR_W-1:0] rom_o [256];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc, ack_delay, wcnt, f0_cnt, ff_cnt;

    logic [3:0]        exp_q[$];
    int                issue_cyc[$];
    logic [ADDR_W-1:0] fetch_log[$];
    logic              err_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: at the negedge, score the ICU outputs, then answer fetches.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (icu_valid) begin
            issue_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("extra_issue", 32'(icu_valid), 32'(0));
            else                   chk("issue", 32'(icu_inst), 32'(exp_q.pop_front()));
        end
        if (flag0) f0_cnt++;
        if (flagf) ff_cnt++;
        if (!rst) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else if (mem_req && !mem_ack) begin
            if (wcnt >= ack_delay) begin
                mem_ack  = 1'b1;
                mem_inst = rom_i[mem_addr];
                mem_opnd = rom_o[mem_addr];
                fetch_log.push_back(mem_addr);
                err_log.push_back(stack_err);
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        halt = 1'b0;
        #1;
        chk("rst_async_mem_req", 32'(mem_req), 32'(0));
        chk("rst_async_pc", 32'(pc), 32'(0));
        tick();
        tick();
        chk("rst_icu_inst", 32'(icu_inst), 32'(0));
        chk("rst_flags", {30'h0, flag0, flagf}, 32'(0));
        chk("rst_stack_err", 32'(stack_err), 32'(0));
        exp_q.delete();
        issue_cyc.delete();
        fetch_log.delete();
        err_log.delete();
        f0_cnt = 0;
        ff_cnt = 0;
        cyc    = 0;
        rst    = 1'b1;
    endtask

    task automatic run(input int slots);
        repeat (2 * slots) tick();
    endtask

    task automatic chk_fetch(input string tag, input int idx, input int exp);
        if (idx < fetch_log.size()) chk(tag, 32'(fetch_log[idx]), 32'(exp));
        else                        chk({tag, "_missing"}, 32'(fetch_log.size()), 32'(idx + 1));
    endtask

    task automatic end_test(input string tag, input int exp_pc);
        @(posedge clk);
        #1;
        chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int ef[11];
        for (int i = 0; i < 256; i++) begin
            rom_i[i] = 4'hB;
            rom_o[i] = '0;
        end
        ack_delay = 0;
        wcnt      = 0;
        cyc       = 0;

        // 1: plain stream, 2-cycle slots
        rom_i[0] = 4'h1; rom_i[1] = 4'h2; rom_i[2] = 4'h3;
        do_reset();
        chk("rst_release_mem_req", 32'(mem_req), 32'(0));
        exp_q.push_back(4'h1); exp_q.push_back(4'h2); exp_q.push_back(4'h3);
        run(3);
        chk_fetch("t1_fetch0", 0, 0);
        chk_fetch("t1_fetch1", 1, 1);
        chk_fetch("t1_fetch2", 2, 2);
        if (issue_cyc.size() == 3) begin
            chk("t1_first_issue_cyc", 32'(issue_cyc[0]), 32'(2));
            chk("t1_slot_len_a", 32'(issue_cyc[1] - issue_cyc[0]), 32'(2));
            chk("t1_slot_len_b", 32'(issue_cyc[2] - issue_cyc[1]), 32'(2));
        end else chk("t1_issue_count", 32'(issue_cyc.size()), 32'(3));
        end_test("t1", 3);

        // 2: call and return
        rom_i[0] = 4'hC; rom_o[0] = 8'h10;
        rom_i[8'h10] = 4'hD;
        rom_i[1] = 4'h5;
        do_reset();
        exp_q.push_back(4'h5);
        run(3);
        chk_fetch("t2_fetch0", 0, 0);
        chk_fetch("t2_fetch1", 1, 'h10);
        chk_fetch("t2_fetch2", 2, 1);
        chk("t2_stack_err", 32'(stack_err), 32'(0));
        end_test("t2", 2);

        // 3a: SKZ with rr=0 skips the next instruction
        rom_i[0] = 4'hE; rom_i[1] = 4'h8; rom_i[2] = 4'h1;
        do_reset();
        rr = 1'b0;
        exp_q.push_back(4'h1);
        run(3);
        chk_fetch("t3a_fetch1", 1, 1);
        chk_fetch("t3a_fetch2", 2, 2);
        end_test("t3a", 3);

        // 3b: SKZ with rr=1 does not skip
        do_reset();
        rr = 1'b1;
        exp_q.push_back(4'h8); exp_q.push_back(4'h1);
        run(3);
        end_test("t3b", 3);

        // 4: five nested calls overflow a 4-deep stack, then unwind past empty
        rom_i[0]     = 4'hC; rom_o[0]     = 8'h10;
        rom_i[8'h10] = 4'hC; rom_o[8'h10] = 8'h20;
        rom_i[8'h20] = 4'hC; rom_o[8'h20] = 8'h30;
        rom_i[8'h30] = 4'hC; rom_o[8'h30] = 8'h40;
        rom_i[8'h40] = 4'hC; rom_o[8'h40] = 8'h50;
        rom_i[8'h50] = 4'hD; rom_i[8'h31] = 4'hD; rom_i[8'h21] = 4'hD;
        rom_i[8'h11] = 4'hD; rom_i[1] = 4'hD; rom_i[2] = 4'h6;
        do_reset();
        exp_q.push_back(4'h6);
        run(11);
        ef = '{0, 'h10, 'h20, 'h30, 'h40, 'h50, 'h31, 'h21, 'h11, 1, 2};
        for (int i = 0; i < 11; i++) chk_fetch($sformatf("t4_fetch%0d", i), i, ef[i]);
        if (err_log.size() == 11) begin
            chk("t4_err_before_5th", 32'(err_log[4]), 32'(0));
            chk("t4_err_after_5th", 32'(err_log[5]), 32'(1));
        end else chk("t4_err_log_count", 32'(err_log.size()), 32'(11));
        end_test("t4", 3);
        chk("t4_err_sticky", 32'(stack_err), 32'(1));

        // 5: slow memory, halt pulse, reset mid-fetch
        rom_i[0] = 4'h2; rom_i[1] = 4'h3;
        ack_delay = 3;
        do_reset();
        exp_q.push_back(4'h2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5_wait_req%0d", i), 32'(mem_req), 32'(1));
            chk($sformatf("t5_wait_addr%0d", i), 32'(mem_addr), 32'(0));
        end
        tick();
        tick();
        if (issue_cyc.size() == 1) chk("t5_issue_cyc", 32'(issue_cyc[0]), 32'(5));
        else                       chk("t5_issue_count", 32'(issue_cyc.size()), 32'(1));
        halt = 1'b1;
        tick();
        chk("t5_halt_req", 32'(mem_req), 32'(0));
        chk("t5_halt_inst", {27'h0, icu_valid, icu_inst}, 32'(0));
        tick();
        chk("t5_halt_hold", 32'(mem_req), 32'(0));
        halt = 1'b0;
        tick();
        chk("t5_resume_req", 32'(mem_req), 32'(1));
        chk("t5_resume_addr", 32'(mem_addr), 32'(1));
        tick();
        rst = 1'b0;
        #1;
        chk("t5_rst_mid_fetch_req", 32'(mem_req), 32'(0));
        chk("t5_rst_mid_fetch_pc", 32'(pc), 32'(0));
        chk("t5_pending", 32'(exp_q.size()), 32'(0));
        ack_delay = 0;

        // 6a: PC wrap
        rom_i[0] = 4'hC; rom_o[0] = 8'hFF;
        rom_i[8'hFF] = 4'h4;
        do_reset();
        exp_q.push_back(4'h4);
        run(3);
        chk_fetch("t6_fetch_ff", 1, 'hFF);
        chk_fetch("t6_fetch_wrap", 2, 0);
        end_test("t6a", 'hFF);

        // 6b: flag pulses, skipped NOP0 raises nothing
        rom_i[0] = 4'hF; rom_i[1] = 4'hE; rom_i[2] = 4'h0; rom_i[3] = 4'h0; rom_i[4] = 4'h9;
        do_reset();
        rr = 1'b0;
        exp_q.push_back(4'h0); exp_q.push_back(4'h9);
        run(5);
        chk("t6_flagf_cycles", 32'(ff_cnt), 32'(1));
        chk("t6_flag0_cycles", 32'(f0_cnt), 32'(1));
        end_test("t6b", 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
